chrom_eval_controller: RTL and testbench

Sequences one fitness evaluation of an evolved circuit for the HPS-driven genetic loop. On an HPS start request it does the following:
- pulses a load of the chromosome into the reconfigurable circuit;
- drives the input sequence step by step, with a settle time per step;
- compares the circuit outputs against the expected outputs under a per-step valid mask;
- accumulates a mismatch count for each repeat.

It then reports completion through a level done/feedback handshake. It sits between the HPS PIO registers (start/done/feedback/ready, sequences, error sums) and the evolvable circuit fabric.

---
 rtl/chrom_eval_controller.sv | 136 +++++++++++++
 tb/tb_chrom_eval_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chrom_eval_controller.sv
// chrom_eval_controller: sequences one fitness evaluation (load, stimulate, compare, accumulate errors per repeat).
// Define EVAL_OUT_SYNC_EN to pass circ_out through a 2-flop synchronizer and stretch each step by 2 cycles.
module chrom_eval_controller #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SEQ_LEN       = 32,
  parameter int REPEATS       = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_processing,
  input  logic                       done_feedback,
  output logic                       ready_to_process,
  output logic                       done_processing,
  input  logic [N_IN*SEQ_LEN-1:0]    input_seq,
  input  logic [N_OUT*SEQ_LEN-1:0]   expected_out,
  input  logic [N_OUT*SEQ_LEN-1:0]   valid_out,
  output logic                       chrom_load,
  output logic [N_IN-1:0]            circ_in,
  input  logic [N_OUT-1:0]           circ_out,
  output logic [32*REPEATS-1:0]      error_sum
);
`ifdef EVAL_OUT_SYNC_EN
  localparam int APPLY_CYC = SETTLE_CYCLES + 2;
`else
  localparam int APPLY_CYC = SETTLE_CYCLES;
`endif
  localparam int TW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  localparam int RW = REPEATS > 1 ? $clog2(REPEATS) : 1;
  localparam int SW = $clog2(APPLY_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, APPLY, REST, DONE, RELEASE} state_t;
  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [RW-1:0]  r_q, r_d;
  logic [SW-1:0]  s_q, s_d;
  logic [31:0]    err_q [REPEATS];
  logic [31:0]    err_d [REPEATS];
  logic [N_OUT-1:0] cmp, diff;
  logic [31:0]    mism;
  logic [32:0]    acc;
  logic           running;
`ifdef EVAL_OUT_SYNC_EN
  logic [N_OUT-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= circ_out;
      sync2_q <= sync1_q;
    end
  end
  assign cmp = sync2_q;
`else
  assign cmp = circ_out;
`endif
  // Masked mismatch count for the current step, pre-added to the active repeat's sum
  always_comb begin
    diff = '0;
    mism = '0;
    for (int k = 0; k < N_OUT; k++) begin
      diff[k] = (cmp[k] ^ expected_out[k*SEQ_LEN + int'(t_q)]) & valid_out[k*SEQ_LEN + int'(t_q)];
      mism = mism + 32'(diff[k]);
    end
    acc = {1'b0, err_q[r_q]} + {1'b0, mism};
  end
  assign running = state_q == LOAD || state_q == APPLY || state_q == REST;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    r_d = r_q;
    s_d = s_q;
    err_d = err_q;
    case (state_q)
      IDLE:    state_d = start_processing ? LOAD : IDLE;
      LOAD: begin
        for (int i = 0; i < REPEATS; i++) err_d[i] = '0;
        t_d = '0;
        r_d = '0;
        s_d = '0;
        state_d = APPLY;
      end
      APPLY: begin
        if (s_q == SW'(APPLY_CYC - 1)) begin
          err_d[r_q] = acc[32] ? '1 : acc[31:0];
          s_d = '0;
          t_d = t_q == TW'(SEQ_LEN - 1) ? '0 : t_q + 1'b1;
          state_d = t_q == TW'(SEQ_LEN - 1) ? REST : APPLY;
        end else s_d = s_q + 1'b1;
      end
      REST: begin
        if (s_q == SW'(SETTLE_CYCLES - 1)) begin
          s_d = '0;
          r_d = r_q == RW'(REPEATS - 1) ? '0 : r_q + 1'b1;
          state_d = r_q == RW'(REPEATS - 1) ? DONE : APPLY;
        end else s_d = s_q + 1'b1;
      end
      DONE:    state_d = done_feedback ? RELEASE : DONE;
      RELEASE: state_d = (!start_processing && !done_feedback) ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
    // Withdrawn request mid-run discards partial results
    if (running && !start_processing) begin
      state_d = IDLE;
      t_d = '0;
      r_d = '0;
      s_d = '0;
      for (int i = 0; i < REPEATS; i++) err_d[i] = '0;
    end
  end
  always_comb begin
    circ_in = '0;
    for (int k = 0; k < N_IN; k++)
      circ_in[k] = state_q == APPLY && input_seq[k*SEQ_LEN + int'(t_q)];
    for (int i = 0; i < REPEATS; i++) error_sum[i*32 +: 32] = err_q[i];
  end
  assign ready_to_process = state_q == IDLE;
  assign done_processing  = state_q == DONE;
  assign chrom_load       = state_q == LOAD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q <= '0;
      r_q <= '0;
      s_q <= '0;
      for (int i = 0; i < REPEATS; i++) err_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      r_q <= r_d;
      s_q <= s_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_chrom_eval_controller.sv
// tb_chrom_eval_controller: default-size and small instances checked against a step-by-step error-count model.
module tb_chrom_eval_controller;
  localparam int BL = 4, BR = 2, BS = 2;
`ifdef EVAL_OUT_SYNC_EN
  localparam int A_LAT = 1 + 8 * (32 * 18 + 16);
  localparam int B_AB  = BS + 2;
`else
  localparam int A_LAT = 1 + 8 * 33 * 16;
  localparam int B_AB  = BS;
`endif
  localparam int B_LAT = 1 + BR * (BL * B_AB + BS);
  logic clk = 0, reset;
  logic a_start, a_fb, a_ready, a_done, a_load;
  logic [127:0] a_seq, a_exp, a_val;
  logic [3:0] a_cin, a_cout;
  logic [255:0] a_sum;
  logic b_start, b_fb, b_ready, b_done, b_load, b_mode;
  logic [7:0] b_seq, b_exp, b_val;
  logic [1:0] b_cin, b_cout;
  logic [63:0] b_sum;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic [7:0] seq, exp, val;
    logic mode;
    logic [31:0] s0, s1;
  } vec_t;
  vec_t tbl [6];
  always #5 clk = ~clk;
  function automatic logic [3:0] fa(input logic [3:0] x);
    return {x[2:0], x[3]} ^ 4'b0110;
  endfunction
  function automatic logic [1:0] fb(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction
  assign a_cout = fa(a_cin);
  assign b_cout = b_mode ? fb(b_cin) : 2'b00;
  chrom_eval_controller dut_a (
    .clk(clk), .reset(reset), .start_processing(a_start), .done_feedback(a_fb),
    .ready_to_process(a_ready), .done_processing(a_done), .input_seq(a_seq),
    .expected_out(a_exp), .valid_out(a_val), .chrom_load(a_load), .circ_in(a_cin),
    .circ_out(a_cout), .error_sum(a_sum));
  chrom_eval_controller #(.N_IN(2), .N_OUT(2), .SEQ_LEN(BL), .REPEATS(BR), .SETTLE_CYCLES(BS)) dut_b (
    .clk(clk), .reset(reset), .start_processing(b_start), .done_feedback(b_fb),
    .ready_to_process(b_ready), .done_processing(b_done), .input_seq(b_seq),
    .expected_out(b_exp), .valid_out(b_val), .chrom_load(b_load), .circ_in(b_cin),
    .circ_out(b_cout), .error_sum(b_sum));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  // One sequence pass: every step's masked output mismatches, repeated identically per repeat
  function automatic int model_a(input logic [127:0] seq, input logic [127:0] exp, input logic [127:0] val);
    int n = 0;
    logic [3:0] x, o;
    for (int t = 0; t < 32; t++) begin
      for (int k = 0; k < 4; k++) x[k] = seq[k*32 + t];
      o = fa(x);
      for (int k = 0; k < 4; k++) if (val[k*32 + t] && o[k] != exp[k*32 + t]) n++;
    end
    return n;
  endfunction
  function automatic int model_b(input logic [7:0] seq, input logic [7:0] exp, input logic [7:0] val, input logic mode);
    int n = 0;
    logic [1:0] x, o;
    for (int t = 0; t < BL; t++) begin
      for (int k = 0; k < 2; k++) x[k] = seq[k*BL + t];
      o = mode ? fb(x) : 2'b00;
      for (int k = 0; k < 2; k++) if (val[k*BL + t] && o[k] != exp[k*BL + t]) n++;
    end
    return n;
  endfunction
  task automatic run_a(input string nm);
    int cnt = 0, loads = 0, want;
    a_start = 1;
    while (!a_done && cnt < A_LAT + 50) begin
      @(negedge clk);
      cnt++;
      loads += int'(a_load);
      if (cnt == 1) chk({nm, " load_pulse"}, a_load, 1);
    end
    chk({nm, " latency"}, cnt, A_LAT + 1);
    chk({nm, " load_count"}, loads, 1);
    want = model_a(a_seq, a_exp, a_val);
    for (int r = 0; r < 8; r++) chk($sformatf("%s sum%0d", nm, r), a_sum[r*32 +: 32], want);
    a_start = 0;
    @(negedge clk);
    chk({nm, " done_holds"}, a_done, 1);
    a_fb = 1;
    @(negedge clk);
    chk({nm, " done_drop"}, a_done, 0);
    a_fb = 0;
    @(negedge clk);
    chk({nm, " ready_back"}, a_ready, 1);
  endtask
  task automatic run_b(input string nm, input logic [31:0] w0, input logic [31:0] w1);
    int cnt = 0, loads = 0;
    b_start = 1;
    while (!b_done && cnt < B_LAT + 50) begin
      @(negedge clk);
      cnt++;
      loads += int'(b_load);
      b_fb = cnt >= 3 && cnt < 6;
    end
    b_fb = 0;
    chk({nm, " latency"}, cnt, B_LAT + 1);
    chk({nm, " load_count"}, loads, 1);
    chk({nm, " sum0"}, b_sum[31:0], w0);
    chk({nm, " sum1"}, b_sum[63:32], w1);
  endtask
  task automatic release_b(input string nm);
    b_start = 0;
    @(negedge clk);
    chk({nm, " done_holds"}, b_done, 1);
    b_fb = 1;
    @(negedge clk);
    chk({nm, " done_drop"}, b_done, 0);
    b_fb = 0;
    @(negedge clk);
    chk({nm, " ready_back"}, b_ready, 1);
  endtask
  initial begin
    int cnt;
    logic seen;
    logic [3:0] x;
    reset = 1;
    {a_start, a_fb, b_start, b_fb, b_mode} = '0;
    {a_seq, a_exp, a_val} = '0;
    {b_seq, b_exp, b_val} = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst ready", b_ready, 1);
    chk("rst done", b_done, 0);
    chk("rst load", b_load, 0);
    chk("rst cin", b_cin, 0);
    chk("rst sums", b_sum, 0);
    chk("rst a_ready", a_ready, 1);
    chk("rst a_sums", a_sum, 0);
    // default size, expected derived from the circuit model so no mismatches
    for (int i = 0; i < 4; i++) a_seq[i*32 +: 32] = $urandom;
    for (int t = 0; t < 32; t++) begin
      for (int k = 0; k < 4; k++) x[k] = a_seq[k*32 + t];
      x = fa(x);
      for (int k = 0; k < 4; k++) a_exp[k*32 + t] = x[k];
    end
    a_val = '1;
    run_a("a_match");
    for (int i = 0; i < 4; i++) begin
      a_seq[i*32 +: 32] = $urandom;
      a_exp[i*32 +: 32] = $urandom;
      a_val[i*32 +: 32] = $urandom;
    end
    run_a("a_rand");
    tbl[0] = '{seq: 8'hA6, exp: 8'h5F, val: 8'hFF, mode: 1'b0, s0: 6, s1: 6};
    tbl[1] = '{seq: 8'h3C, exp: 8'h5F, val: 8'h03, mode: 1'b0, s0: 2, s1: 2};
    for (int i = 2; i < 6; i++) begin
      tbl[i].seq = 8'($urandom);
      tbl[i].exp = 8'($urandom);
      tbl[i].val = 8'($urandom);
      tbl[i].mode = 1'b1;
      tbl[i].s0 = model_b(tbl[i].seq, tbl[i].exp, tbl[i].val, 1'b1);
      tbl[i].s1 = tbl[i].s0;
    end
    for (int i = 0; i < 6; i++) begin
      {b_seq, b_exp, b_val, b_mode} = {tbl[i].seq, tbl[i].exp, tbl[i].val, tbl[i].mode};
      run_b($sformatf("vec%0d", i), tbl[i].s0, tbl[i].s1);
      release_b($sformatf("vec%0d", i));
    end
    // long hold in DONE, then feedback with start still high
    {b_seq, b_exp, b_val, b_mode} = {tbl[0].seq, tbl[0].exp, tbl[0].val, tbl[0].mode};
    run_b("hs", 6, 6);
    repeat (100) @(negedge clk);
    chk("hs done_after_100", b_done, 1);
    b_fb = 1;
    @(negedge clk);
    chk("hs done_drop", b_done, 0);
    chk("hs ready_low", b_ready, 0);
    repeat (3) @(negedge clk);
    b_fb = 0;
    @(negedge clk);
    chk("hs ready_start_high", b_ready, 0);
    chk("hs no_restart", b_load, 0);
    b_start = 0;
    @(negedge clk);
    chk("hs ready_back", b_ready, 1);
    // abort during repeat 1 step 3
    b_start = 1;
    cnt = 0;
    seen = 0;
    while (cnt < 2 + BL * B_AB + BS + 3 * B_AB) begin
      @(negedge clk);
      cnt++;
      seen |= b_done;
    end
    chk("abort pre_sum0", b_sum[31:0], 6);
    b_start = 0;
    @(negedge clk);
    seen |= b_done;
    chk("abort ready", b_ready, 1);
    chk("abort cin", b_cin, 0);
    chk("abort sums", b_sum, 0);
    repeat (5) @(negedge clk) seen |= b_done;
    chk("abort never_done", seen, 0);
    run_b("rerun", 6, 6);
    // reset while DONE with nonzero sums
    reset = 1;
    @(negedge clk);
    chk("rstdone ready", b_ready, 1);
    chk("rstdone done", b_done, 0);
    chk("rstdone load", b_load, 0);
    chk("rstdone cin", b_cin, 0);
    chk("rstdone sums", b_sum, 0);
    b_start = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rstdone idle", b_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
